// File: rtl/serial_tx_buffer_if.sv
// CPU-side bundle for the serial transmit buffer: push strobe, data word and
// the line/status outputs fed back to the controller.
interface serial_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  serial_send;
    logic [15:0]           serial_data_out;
    logic                  txd;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  busy;
    logic                  overflow;

    modport master (
        output serial_send,
        output serial_data_out,
        input  txd,
        input  full,
        input  empty,
        input  count,
        input  busy,
        input  overflow
    );

    modport slave (
        input  serial_send,
        input  serial_data_out,
        output txd,
        output full,
        output empty,
        output count,
        output busy,
        output overflow
    );
endinterface

// File: rtl/serial_tx_buffer.sv
// Word FIFO feeding a UART 8N1 transmitter; each 16-bit word leaves as two
// back-to-back frames, low byte first.
module serial_tx_buffer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    serial_tx_buffer_if.slave   bus
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [15:0]         BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;

    state_e                state_q, state_d;
    logic [15:0]           baud_q, baud_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic                  byte_sel_q, byte_sel_d;
    logic [15:0]           hold_q, hold_d;
    logic                  txd_q, txd_d;
    logic [7:0]            tx_byte;

    logic                  push;
    logic                  pop;
    logic                  baud_done;

    // Full is the registered flag, so a pop in the same cycle never frees room.
    assign push      = bus.serial_send & ~full_q;
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (bus.serial_send && full_q) begin
            overflow_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        hold_d     = hold_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    hold_d     = mem_q[rd_ptr_q];
                    byte_sel_d = 1'b0;
                    baud_d     = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the next state so the start bit appears right after the pop edge.
        tx_byte = byte_sel_d ? hold_d[15:8] : hold_d[7:0];
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = tx_byte[bit_idx_d];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            hold_q     <= '0;
            txd_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            hold_q     <= hold_d;
            txd_q      <= txd_d;
        end
    end

    // Storage needs no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.serial_data_out;
        end
    end

    assign bus.txd      = txd_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.overflow = overflow_q;

endmodule

// File: doc/serial_tx_buffer.md
Name: serial_tx_buffer

Overview:
Transmit-side serial stage directly downstream of the CPU's SerialSend/SerialDataOut outputs. It captures each 16-bit word the CPU sends into a FIFO and serialises it onto a UART line as two 8N1 frames, low byte first. Decouples CPU instruction timing from baud timing and reports fullness so the controller can stall or poll.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
DEPTH_LOG2, 3, log2 of FIFO depth in 16-bit words (default depth 8)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset
SerialSend  input  1  push strobe from CPU, one word per asserted cycle
SerialDataOut  input  16  word to transmit, sampled when SerialSend=1
TxD  output  1  UART serial line, idle high
Full  output  1  FIFO holds DEPTH words
Empty  output  1  FIFO holds 0 words
Count  output  DEPTH_LOG2+1  current FIFO occupancy
Busy  output  1  transmitter not in IDLE
Overflow  output  1  sticky: a push was dropped because FIFO was full

Behaviour:
- Reset (Reset=0 at rising edge): TxD=1, Full=0, Empty=1, Count=0, Busy=0, Overflow=0; FIFO pointers, bit counter, baud counter cleared; FSM to IDLE. Reset mid-frame aborts immediately; TxD returns high the cycle after; buffered words are discarded.
- FIFO: circular, rd/wr pointers DEPTH_LOG2 bits, wrap modulo DEPTH. Full/Empty/Count are registered, derived from Count.
- Push: SerialSend=1 and Full=0 -> word written at wr_ptr, wr_ptr+1. SerialSend=1 and Full=1 -> word dropped, Overflow set to 1 and held until reset. Full is evaluated on the registered value; a pop in the same cycle does not allow a push into a full FIFO.
- Pop: occurs only in IDLE when Empty=0; word loaded into 16-bit holding register, rd_ptr+1.
- Simultaneous push and pop (not full): Count unchanged; both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  IDLE: TxD=1, Busy=0. If Empty=0: pop, byte_sel=0, -> START.
  START: TxD=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
  DATA: TxD = selected byte bit bit_idx (LSB first), each held CLKS_PER_BIT cycles; after bit 7 -> STOP.
  STOP: TxD=1 for CLKS_PER_BIT cycles. Then if byte_sel=0: byte_sel=1 -> START (high byte, no idle gap). If byte_sel=1 -> IDLE.
- Selected byte: byte_sel=0 -> hold[7:0]; byte_sel=1 -> hold[15:8].
- Busy=1 in START, DATA, STOP.
- Latency: push at edge N into an empty FIFO with FSM in IDLE -> Empty=0 after N; pop and START entry at edge N+1; TxD falls after edge N+1. One word = 20 bit-times = 20*CLKS_PER_BIT cycles, plus one IDLE cycle between consecutive words.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state/bit change; no drift accumulates across bits.
- TxD is driven from a register (glitch-free).

Test Plan:
- Reset: hold Reset=0 2 cycles, CLKS_PER_BIT=4 -> TxD=1, Empty=1, Count=0, Busy=0, Overflow=0.
- Single word: push 16'hA53C, CLKS_PER_BIT=4 -> TxD emits 0,0,0,1,1,1,1,0,0,1 then 0,1,0,1,0,0,1,0,1,1 (bits of 3C then A5), each 4 cycles; Busy=0 and TxD=1 after 80 cycles.
- Fill/overflow: DEPTH_LOG2=2; push 6 words back-to-back while the first is transmitting -> first popped, next 4 stored (Count=4, Full=1), 6th dropped, Overflow=1; the 5 accepted words are later transmitted in order.
- Simultaneous push/pop: Count=2, FSM returns to IDLE on the same cycle as a push -> Count stays 2, pointers advance, word order preserved.
- Pointer wrap: DEPTH_LOG2=2, stream 10 words with gaps keeping Count<=2 -> all 10 transmitted in order, no Overflow.
- Reset mid-frame: assert Reset=0 during DATA bit 3 of a high byte -> next cycle TxD=1, Busy=0, Count=0; a subsequent push of 16'h0001 transmits cleanly.
